// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar and its per-lane output FIFOs.
// Provides the default message width and depth, plus helpers that
// derive the FIFO pointer and occupancy-counter widths from the depth.
`timescale 1ns/1ps
package crossbar_pkg;

    localparam int unsigned DEFAULT_BIT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH     = 4;

    // Pointer width: indexes DEPTH entries.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Counter width: one extra bit so the value DEPTH is representable.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x BIT_WIDTH register file backing the output FIFO.
// Ports:
//   clk   - clock
//   we    - write enable (synchronous write on rising edge)
//   waddr - write address
//   wdata - write data
//   raddr - read address (combinational read)
//   rdata - read data
// Contents are intentionally not reset.
`timescale 1ns/1ps
module fifo_regfile
    import crossbar_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter int unsigned DEPTH     = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [ptr_width(DEPTH)-1:0] waddr,
    input  logic [BIT_WIDTH-1:0]        wdata,
    input  logic [ptr_width(DEPTH)-1:0] raddr,
    output logic [BIT_WIDTH-1:0]        rdata
);

    logic [BIT_WIDTH-1:0] r_mem [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Combinational read port.
    assign rdata = r_mem[raddr];

endmodule

// File: rtl/crossbar_output_fifo.sv
// Elastic output buffer downstream of one crossbar output lane.
// Ports:
//   clk      - clock
//   reset    - asynchronous active-low reset (pointers and count only)
//   recv_msg - incoming message
//   recv_val - incoming message valid
//   recv_rdy - FIFO can accept (registered, count != DEPTH)
//   send_msg - head-of-queue message (undefined while send_val is 0)
//   send_val - head entry valid (registered, count != 0)
//   send_rdy - consumer accepts the head
//   clear    - synchronous flush, overrides any concurrent transfer
//   count    - number of occupied entries, 0..DEPTH
`timescale 1ns/1ps
module crossbar_output_fifo
    import crossbar_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter int unsigned DEPTH     = DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BIT_WIDTH-1:0]          recv_msg,
    input  logic                          recv_val,
    output logic                          recv_rdy,
    output logic [BIT_WIDTH-1:0]          send_msg,
    output logic                          send_val,
    input  logic                          send_rdy,
    input  logic                          clear,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_recv_rdy;
    logic          r_send_val;

    logic          w_enq;
    logic          w_deq;
    logic          w_we;
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [PW-1:0] w_rd_ptr_nxt;
    logic [CW-1:0] w_count_nxt;
    logic          w_recv_rdy_nxt;
    logic          w_send_val_nxt;
    logic [BIT_WIDTH-1:0] w_rdata;

    // Handshakes use only registered flags, so recv_rdy never sees send_rdy.
    assign w_enq = recv_val && r_recv_rdy;
    assign w_deq = r_send_val && send_rdy;
    // A write during clear is dropped; storage is left untouched.
    assign w_we  = w_enq && !clear;

    // Next-state for pointers, count and the registered status flags.
    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_count_nxt    = r_count;
        w_recv_rdy_nxt = r_recv_rdy;
        w_send_val_nxt = r_send_val;
        if (clear) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (w_enq) begin
                w_wr_ptr_nxt = r_wr_ptr + PW'(1);
            end
            if (w_deq) begin
                w_rd_ptr_nxt = r_rd_ptr + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
        w_recv_rdy_nxt = (w_count_nxt != CW'(DEPTH));
        w_send_val_nxt = (w_count_nxt != CW'(0));
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_recv_rdy <= 1'b1;
            r_send_val <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_recv_rdy <= w_recv_rdy_nxt;
            r_send_val <= w_send_val_nxt;
        end
    end

    fifo_regfile #(
        .BIT_WIDTH (BIT_WIDTH),
        .DEPTH     (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wr_ptr),
        .wdata (recv_msg),
        .raddr (r_rd_ptr),
        .rdata (w_rdata)
    );

    assign recv_rdy = r_recv_rdy;
    assign send_val = r_send_val;
    assign send_msg = w_rdata;
    assign count    = r_count;

endmodule

// File: tb/tb_crossbar_output_fifo.sv
// Self-checking bench for crossbar_output_fifo (DEPTH=4, BIT_WIDTH=32).
// A queue holds the expected FIFO contents; occupancy and flags derive from it.
`timescale 1ns/1ps
module tb_crossbar_output_fifo;

    localparam int unsigned BW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          reset;
    logic [BW-1:0] recv_msg;
    logic          recv_val;
    logic          recv_rdy;
    logic [BW-1:0] send_msg;
    logic          send_val;
    logic          send_rdy;
    logic          clear;
    logic [2:0]    count;

    int checks;
    int errors;
    logic [BW-1:0] q[$];

    crossbar_output_fifo #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_msg (recv_msg),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_msg (send_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .clear    (clear),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs at negedge, compare against the model, advance
    // the model across the rising edge, return at the next negedge.
    task automatic drive(input logic rv, input logic [BW-1:0] m, input logic sr, input logic clr);
        bit enq;
        bit deq;
        recv_val = rv;
        recv_msg = m;
        send_rdy = sr;
        clear    = clr;
        #1;
        chk("count", BW'(count), BW'(q.size()));
        chk("recv_rdy", BW'(recv_rdy), BW'(q.size() != DEPTH));
        chk("send_val", BW'(send_val), BW'(q.size() != 0));
        if (q.size() != 0) chk("send_msg", send_msg, q[0]);
        enq = rv && (q.size() != DEPTH);
        deq = sr && (q.size() != 0);
        @(posedge clk);
        if (clr) begin
            q.delete();
        end else begin
            if (deq) void'(q.pop_front());
            if (enq) q.push_back(m);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic          rv;
        logic [BW-1:0] msg;
        logic          sr;
        int            exp_count;
        logic          exp_rdy;
        logic          exp_val;
        logic [BW-1:0] exp_msg;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic rv, input logic [BW-1:0] m, input logic sr,
                                input int c, input logic r, input logic v, input logic [BW-1:0] em);
        vec_t t;
        t.rv = rv; t.msg = m; t.sr = sr;
        t.exp_count = c; t.exp_rdy = r; t.exp_val = v; t.exp_msg = em;
        return t;
    endfunction

    initial begin
        logic          rv;
        logic          sr;
        logic [BW-1:0] m;
        logic          rdy_a;
        int            maxc;

        checks = 0;
        errors = 0;

        // Fill to full, attempt a fifth write, then drain in order.
        vecs[0]  = mk(1, 32'hA0, 0, 0, 1, 0, 32'h0);
        vecs[1]  = mk(1, 32'hA1, 0, 1, 1, 1, 32'hA0);
        vecs[2]  = mk(1, 32'hA2, 0, 2, 1, 1, 32'hA0);
        vecs[3]  = mk(1, 32'hA3, 0, 3, 1, 1, 32'hA0);
        vecs[4]  = mk(1, 32'hA4, 0, 4, 0, 1, 32'hA0);
        vecs[5]  = mk(0, 32'hA4, 1, 4, 0, 1, 32'hA0);
        vecs[6]  = mk(0, 32'h0,  1, 3, 1, 1, 32'hA1);
        vecs[7]  = mk(0, 32'h0,  1, 2, 1, 1, 32'hA2);
        vecs[8]  = mk(0, 32'h0,  1, 1, 1, 1, 32'hA3);
        vecs[9]  = mk(0, 32'h0,  0, 0, 1, 0, 32'h0);
        vecs[10] = mk(0, 32'h0,  0, 0, 1, 0, 32'h0);

        reset = 1'b0;
        recv_val = 1'b0;
        recv_msg = '0;
        send_rdy = 1'b0;
        clear = 1'b0;
        #13;
        chk("reset_count", BW'(count), 32'd0);
        chk("reset_recv_rdy", BW'(recv_rdy), 32'd1);
        chk("reset_send_val", BW'(send_val), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            recv_val = vecs[i].rv;
            recv_msg = vecs[i].msg;
            send_rdy = vecs[i].sr;
            #1;
            chk($sformatf("vec%0d_count", i), BW'(count), BW'(vecs[i].exp_count));
            chk($sformatf("vec%0d_recv_rdy", i), BW'(recv_rdy), BW'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_send_val", i), BW'(send_val), BW'(vecs[i].exp_val));
            if (vecs[i].exp_val) chk($sformatf("vec%0d_send_msg", i), send_msg, vecs[i].exp_msg);
            drive(vecs[i].rv, vecs[i].msg, vecs[i].sr, 1'b0);
        end

        // Streaming with both sides always ready: occupancy settles at one.
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                #1;
                chk("stream_count", BW'(count), 32'd1);
                chk("stream_msg", send_msg, BW'(32'h100 + i - 1));
            end
            drive(1'b1, BW'(32'h100 + i), 1'b1, 1'b0);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);

        // Full with simultaneous demand: dequeue only, pending write lands next.
        for (int i = 0; i < 4; i++) drive(1'b1, BW'(32'hB0 + i), 1'b0, 1'b0);
        drive(1'b1, 32'hB4, 1'b1, 1'b0);
        #1;
        chk("full_demand_count", BW'(count), 32'd3);
        chk("full_demand_rdy", BW'(recv_rdy), 32'd1);
        drive(1'b1, 32'hB4, 1'b0, 1'b0);
        #1;
        chk("full_pending_count", BW'(count), 32'd4);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);

        // Clear during a concurrent enqueue: the dropped message never surfaces.
        drive(1'b1, 32'hC0, 1'b0, 1'b0);
        drive(1'b1, 32'hC1, 1'b0, 1'b0);
        drive(1'b1, 32'hDEAD, 1'b1, 1'b1);
        #1;
        chk("clear_count", BW'(count), 32'd0);
        chk("clear_send_val", BW'(send_val), 32'd0);
        drive(1'b1, 32'hC2, 1'b0, 1'b0);
        #1;
        chk("after_clear_msg", send_msg, 32'hC2);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset between edges with three entries queued.
        for (int i = 0; i < 3; i++) drive(1'b1, BW'(32'hD0 + i), 1'b0, 1'b0);
        recv_val = 1'b0;
        #1;
        chk("pre_reset_count", BW'(count), 32'd3);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_count", BW'(count), 32'd0);
        chk("async_reset_rdy", BW'(recv_rdy), 32'd1);
        chk("async_reset_val", BW'(send_val), 32'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 32'hE0, 1'b0, 1'b0);
        #1;
        chk("post_reset_msg", send_msg, 32'hE0);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Random backpressure; upstream holds a refused message stable.
        rv = 1'b0;
        m = 32'h1000;
        maxc = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!(rv && (q.size() == DEPTH))) begin
                rv = 1'($urandom_range(0, 1));
                if (rv) m = $urandom;
            end
            sr = 1'($urandom_range(0, 1));
            recv_val = rv;
            recv_msg = m;
            send_rdy = ~sr;
            #1;
            rdy_a = recv_rdy;
            send_rdy = sr;
            #1;
            chk("rdy_indep_of_send_rdy", BW'(recv_rdy), BW'(rdy_a));
            if (int'(count) > maxc) maxc = int'(count);
            drive(rv, m, sr, 1'b0);
            if (rv && (q.size() != 0) && (q[q.size()-1] == m)) rv = 1'b0;
        end
        chk("random_max_count_le_4", BW'(maxc <= 4), 32'd1);
        while (q.size() != 0) drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
